wb_cmd_master: RTL and testbench

WB_CMD_MASTER -- requirements
Module: wb_cmd_master

---
 rtl/wb_cmd_master.sv | 171 +++++++++++++++++
 tb/tb_wb_cmd_master.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_cmd_master.sv
// wb_cmd_master
// Turns a single valid/ready command into one classic Wishbone cycle and
// hands the outcome back on a valid/ready response channel. A bounded wait
// counter stops a silent slave from stalling the command channel forever.

module wb_cmd_master #(
  parameter int TIMEOUT = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,

  // Command channel
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,

  // Response channel
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        rsp_tmo,

  // Wishbone initiator
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,

  // Status
  output logic        busy
);

  // The wait counter is 8 bits wide, so the limit is compared at that width.
  localparam logic [7:0] TimeoutLimit = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  waitCnt_q, waitCnt_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [31:0] rspDat_q, rspDat_d;
  logic        rspErr_q, rspErr_d;
  logic        rspTmo_q, rspTmo_d;

  // Next-state and datapath: accept in IDLE, wait for ack/err/timeout in BUS,
  // then hold the response in RESP until the consumer takes it.
  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    cyc_d     = cyc_q;
    we_d      = we_q;
    sel_d     = sel_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    rspDat_d  = rspDat_q;
    rspErr_d  = rspErr_q;
    rspTmo_d  = rspTmo_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          we_d      = cmd_we;
          sel_d     = cmd_sel;
          adr_d     = cmd_adr;
          dat_d     = cmd_dat;
          cyc_d     = 1'b1;
          waitCnt_d = 8'd0;
          state_d   = BUS;
        end
      end

      BUS: begin
        // err outranks ack, and either outranks a timeout hitting the same cycle
        if (wbm_err_i) begin
          rspErr_d = 1'b1;
          rspTmo_d = 1'b0;
          rspDat_d = 32'd0;
          cyc_d    = 1'b0;
          state_d  = RESP;
        end else if (wbm_ack_i) begin
          rspErr_d = 1'b0;
          rspTmo_d = 1'b0;
          rspDat_d = we_q ? 32'd0 : wbm_dat_i;
          cyc_d    = 1'b0;
          state_d  = RESP;
        end else if (waitCnt_q == TimeoutLimit) begin
          rspErr_d = 1'b1;
          rspTmo_d = 1'b1;
          rspDat_d = 32'd0;
          cyc_d    = 1'b0;
          state_d  = RESP;
        end else begin
          waitCnt_d = waitCnt_q + 8'd1;
        end
      end

      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        cyc_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any transaction in flight.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= IDLE;
      waitCnt_q <= 8'd0;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      sel_q     <= 4'd0;
      adr_q     <= 32'd0;
      dat_q     <= 32'd0;
      rspDat_q  <= 32'd0;
      rspErr_q  <= 1'b0;
      rspTmo_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
      cyc_q     <= cyc_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      rspDat_q  <= rspDat_d;
      rspErr_q  <= rspErr_d;
      rspTmo_q  <= rspTmo_d;
    end
  end

  // Handshake and status outputs depend only on state, never on cmd_valid.
  assign cmd_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);

  // stb mirrors cyc because there is exactly one beat per cycle.
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = sel_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;

  assign rsp_dat = rspDat_q;
  assign rsp_err = rspErr_q;
  assign rsp_tmo = rspTmo_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Bench for wb_cmd_master: directed vector table, reset corner cases and a
// randomized run scored against a transaction-level response model.

module tb_wb_cmd_master;

  localparam int TMO    = 4;
  localparam int K_ACK  = 0;
  localparam int K_ERR  = 1;
  localparam int K_BOTH = 2;
  localparam int K_NONE = 3;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr, cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_tmo;
  logic [31:0] rsp_dat;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic        wbm_ack_i, wbm_err_i;
  logic        busy;

  int compared   = 0;
  int mismatched = 0;
  string curTag  = "init";

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          delay;
    int          kind;
    logic [31:0] rdData;
    int          rspWait;
    logic        expErr;
    logic        expTmo;
    logic [31:0] expDat;
    int          expCycles;
  } vec_t;

  vec_t vecs[8];

  wb_cmd_master #(.TIMEOUT(TMO)) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_we   (cmd_we),
    .cmd_adr  (cmd_adr),
    .cmd_dat  (cmd_dat),
    .cmd_sel  (cmd_sel),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_dat  (rsp_dat),
    .rsp_err  (rsp_err),
    .rsp_tmo  (rsp_tmo),
    .wbm_cyc_o(wbm_cyc_o),
    .wbm_stb_o(wbm_stb_o),
    .wbm_we_o (wbm_we_o),
    .wbm_sel_o(wbm_sel_o),
    .wbm_adr_o(wbm_adr_o),
    .wbm_dat_o(wbm_dat_o),
    .wbm_dat_i(wbm_dat_i),
    .wbm_ack_i(wbm_ack_i),
    .wbm_err_i(wbm_err_i),
    .busy     (busy)
  );

  // Free-running clock, period 10
  always #5 wb_clk_i = ~wb_clk_i;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s/%s: got 0x%08h, expected 0x%08h", curTag, name, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge
  task automatic nextCycle();
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
  endtask

  task automatic quietBus();
    wbm_ack_i = 1'b0;
    wbm_err_i = 1'b0;
    wbm_dat_i = $urandom;
  endtask

  // Transaction-level model: what the master must report for a given responder behaviour
  function automatic vec_t buildVec(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                                    input logic [3:0] sel, input int delay, input int kind,
                                    input logic [31:0] rdData, input int rspWait);
    vec_t v;
    v.we = we; v.adr = adr; v.dat = dat; v.sel = sel;
    v.delay = delay; v.kind = kind; v.rdData = rdData; v.rspWait = rspWait;
    if (kind == K_NONE || delay > TMO) begin
      v.expCycles = TMO + 1;
      v.expErr = 1'b1; v.expTmo = 1'b1; v.expDat = 32'd0;
    end else begin
      v.expCycles = delay + 1;
      v.expTmo = 1'b0;
      v.expErr = (kind != K_ACK);
      v.expDat = (kind == K_ACK && !we) ? rdData : 32'd0;
    end
    return v;
  endfunction

  // One full command -> bus -> response transaction, checked cycle by cycle
  task automatic applyStimulus(input vec_t v);
    checkOutput("cmdReadyIdle", 32'(cmd_ready), 32'd1);
    checkOutput("busyIdle", 32'(busy), 32'd0);
    cmd_valid = 1'b1; cmd_we = v.we; cmd_adr = v.adr; cmd_dat = v.dat; cmd_sel = v.sel;
    rsp_ready = 1'b0;
    quietBus();
    nextCycle();
    cmd_valid = 1'b0;
    cmd_we = ~v.we; cmd_adr = $urandom; cmd_dat = $urandom; cmd_sel = 4'($urandom);
    for (int i = 0; i < v.expCycles; i++) begin
      checkOutput("cycStbHigh", 32'({wbm_cyc_o, wbm_stb_o}), 32'd3);
      checkOutput("busWe", 32'(wbm_we_o), 32'(v.we));
      checkOutput("busAdr", wbm_adr_o, v.adr);
      checkOutput("busDat", wbm_dat_o, v.dat);
      checkOutput("busSel", 32'(wbm_sel_o), 32'(v.sel));
      checkOutput("busyBus", 32'(busy), 32'd1);
      checkOutput("cmdReadyBus", 32'(cmd_ready), 32'd0);
      checkOutput("rspValidBus", 32'(rsp_valid), 32'd0);
      if (v.kind != K_NONE && i == v.delay) begin
        wbm_ack_i = (v.kind == K_ACK || v.kind == K_BOTH);
        wbm_err_i = (v.kind == K_ERR || v.kind == K_BOTH);
        wbm_dat_i = v.rdData;
      end else begin
        quietBus();
      end
      nextCycle();
    end
    quietBus();
    checkOutput("cycDropped", 32'({wbm_cyc_o, wbm_stb_o}), 32'd0);
    checkOutput("rspValid", 32'(rsp_valid), 32'd1);
    checkOutput("rspErr", 32'(rsp_err), 32'(v.expErr));
    checkOutput("rspTmo", 32'(rsp_tmo), 32'(v.expTmo));
    checkOutput("rspDat", rsp_dat, v.expDat);
    for (int i = 0; i < v.rspWait; i++) begin
      wbm_ack_i = 1'($urandom_range(0, 1));
      wbm_err_i = 1'($urandom_range(0, 1));
      wbm_dat_i = $urandom;
      nextCycle();
      checkOutput("rspValidHeld", 32'(rsp_valid), 32'd1);
      checkOutput("rspDatHeld", rsp_dat, v.expDat);
      checkOutput("rspErrHeld", 32'(rsp_err), 32'(v.expErr));
      checkOutput("rspTmoHeld", 32'(rsp_tmo), 32'(v.expTmo));
      checkOutput("cmdReadyResp", 32'(cmd_ready), 32'd0);
      checkOutput("cycResp", 32'(wbm_cyc_o), 32'd0);
    end
    quietBus();
    rsp_ready = 1'b1;
    nextCycle();
    rsp_ready = 1'b0;
    checkOutput("rspValidCleared", 32'(rsp_valid), 32'd0);
    checkOutput("cmdReadyAfterRsp", 32'(cmd_ready), 32'd1);
  endtask

  // Outputs expected while reset is held, with no clock edge involved
  task automatic checkResetState();
    checkOutput("rstCyc", 32'(wbm_cyc_o), 32'd0);
    checkOutput("rstStb", 32'(wbm_stb_o), 32'd0);
    checkOutput("rstWe", 32'(wbm_we_o), 32'd0);
    checkOutput("rstSel", 32'(wbm_sel_o), 32'd0);
    checkOutput("rstAdr", wbm_adr_o, 32'd0);
    checkOutput("rstDat", wbm_dat_o, 32'd0);
    checkOutput("rstRspValid", 32'(rsp_valid), 32'd0);
    checkOutput("rstRspDat", rsp_dat, 32'd0);
    checkOutput("rstRspErr", 32'(rsp_err), 32'd0);
    checkOutput("rstRspTmo", 32'(rsp_tmo), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstCmdReady", 32'(cmd_ready), 32'd1);
  endtask

  // Pulse reset between clock edges and check that it acts immediately
  task automatic pulseReset();
    #1 wb_rst_i = 1'b1;
    #1 checkResetState();
    #1 wb_rst_i = 1'b0;
  endtask

  initial begin
    vec_t v;
    wb_rst_i = 1'b1;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
    rsp_ready = 1'b0;
    wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_dat_i = '0;

    #2;
    curTag = "powerOnReset";
    checkResetState();
    @(negedge wb_clk_i);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    nextCycle();

    // Directed vectors with hand-derived expectations
    vecs[0] = '{we:1'b1, adr:32'h3000_0000, dat:32'hA5A5_0F0F, sel:4'hF, delay:0, kind:K_ACK,
                rdData:32'hDEAD_BEEF, rspWait:0, expErr:1'b0, expTmo:1'b0, expDat:32'h0, expCycles:1};
    vecs[1] = '{we:1'b0, adr:32'h0000_0040, dat:32'h0, sel:4'hF, delay:3, kind:K_ACK,
                rdData:32'h1234_5678, rspWait:1, expErr:1'b0, expTmo:1'b0, expDat:32'h1234_5678, expCycles:4};
    vecs[2] = '{we:1'b0, adr:32'h0000_0080, dat:32'h0, sel:4'h3, delay:0, kind:K_NONE,
                rdData:32'h0, rspWait:0, expErr:1'b1, expTmo:1'b1, expDat:32'h0, expCycles:5};
    vecs[3] = '{we:1'b0, adr:32'h0000_00C0, dat:32'h0, sel:4'hC, delay:1, kind:K_BOTH,
                rdData:32'hCAFE_F00D, rspWait:0, expErr:1'b1, expTmo:1'b0, expDat:32'h0, expCycles:2};
    vecs[4] = '{we:1'b0, adr:32'h1000_0004, dat:32'h0, sel:4'hF, delay:0, kind:K_ACK,
                rdData:32'h0BAD_F00D, rspWait:10, expErr:1'b0, expTmo:1'b0, expDat:32'h0BAD_F00D, expCycles:1};
    vecs[5] = '{we:1'b0, adr:32'h1000_0008, dat:32'h0, sel:4'h1, delay:4, kind:K_ACK,
                rdData:32'h7777_8888, rspWait:0, expErr:1'b0, expTmo:1'b0, expDat:32'h7777_8888, expCycles:5};
    vecs[6] = '{we:1'b1, adr:32'h1000_000C, dat:32'h5555_AAAA, sel:4'h6, delay:4, kind:K_ERR,
                rdData:32'h0, rspWait:2, expErr:1'b1, expTmo:1'b0, expDat:32'h0, expCycles:5};
    vecs[7] = '{we:1'b1, adr:32'hFFFF_FFFC, dat:32'hFFFF_FFFF, sel:4'h8, delay:2, kind:K_ERR,
                rdData:32'h1111_2222, rspWait:3, expErr:1'b1, expTmo:1'b0, expDat:32'h0, expCycles:3};

    for (int i = 0; i < 8; i++) begin
      curTag = $sformatf("vec%0d", i);
      applyStimulus(vecs[i]);
    end

    // Reset in the middle of a bus cycle: no response, next command normal
    curTag = "resetMidBus";
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h2000_0000; cmd_dat = 32'h0102_0304; cmd_sel = 4'hF;
    nextCycle();
    cmd_valid = 1'b0;
    quietBus();
    nextCycle();
    checkOutput("cycBeforeReset", 32'(wbm_cyc_o), 32'd1);
    pulseReset();
    wbm_ack_i = 1'b1;
    nextCycle();
    quietBus();
    checkOutput("noRspAfterReset", 32'(rsp_valid), 32'd0);
    checkOutput("noCycAfterReset", 32'(wbm_cyc_o), 32'd0);
    checkOutput("readyAfterReset", 32'(cmd_ready), 32'd1);
    applyStimulus(buildVec(1'b0, 32'h2000_0010, 32'h0, 4'hF, 1, K_ACK, 32'h600D_CAFE, 1));

    // Reset while a failed response is waiting to be consumed
    curTag = "resetInResp";
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h2000_0020; cmd_sel = 4'hF;
    nextCycle();
    cmd_valid = 1'b0;
    wbm_err_i = 1'b1;
    nextCycle();
    quietBus();
    checkOutput("respBeforeReset", 32'({rsp_valid, rsp_err}), 32'd3);
    pulseReset();
    nextCycle();
    checkOutput("respDropped", 32'(rsp_valid), 32'd0);

    // Randomized transactions with idle gaps carrying stray ack/err
    for (int n = 0; n < 60; n++) begin
      curTag = $sformatf("rand%0d", n);
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        wbm_ack_i = 1'($urandom_range(0, 1));
        wbm_err_i = 1'($urandom_range(0, 1));
        nextCycle();
        checkOutput("idleNoCyc", 32'(wbm_cyc_o), 32'd0);
        checkOutput("idleNoRsp", 32'(rsp_valid), 32'd0);
      end
      quietBus();
      v = buildVec(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom),
                   $urandom_range(0, TMO + 2), $urandom_range(0, 3), $urandom,
                   $urandom_range(0, 3));
      applyStimulus(v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
